// File: rtl/floo_pkg.sv
// Shared types for the FlooNoC router slice: the output-arbiter state encoding
// and a helper function that computes index widths.
package floo_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   // An index must be at least one bit wide, even when there is only one port.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/floo_rr_pick.sv
// Rotate-priority picker: returns the first requester at or after rr_ptr
// (mod NumReq), or rr_ptr itself when nobody is requesting.
module floo_rr_pick
   import floo_pkg::*;
#(
   parameter int NumReq   = 5,
   parameter int IdxWidth = idx_width(NumReq)
) (
   input  logic [NumReq-1:0]   req,
   input  logic [IdxWidth-1:0] rr_ptr,
   output logic [IdxWidth-1:0] idx,
   output logic                any
);

   int cand;

   always_comb begin
      idx  = rr_ptr;
      cand = 0;
      // Scan from the farthest offset down, so the nearest requester wins.
      for (int k = NumReq - 1; k >= 0; k--) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NumReq) begin
            cand = cand - NumReq;
         end
         if (req[cand]) begin
            idx = IdxWidth'(cand);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/floo_wormhole_arbiter.sv
// Round-robin output-port arbiter that holds its grant for a whole packet, so
// flits of different packets are never interleaved on the shared link.
module floo_wormhole_arbiter
   import floo_pkg::*;
#(
   parameter  int NumInputs = 5,
   parameter  int DataWidth = 64,
   localparam int IdxWidth  = idx_width(NumInputs)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NumInputs-1:0]                valid_i,
   output logic [NumInputs-1:0]                ready_o,
   input  logic [NumInputs-1:0][DataWidth-1:0] data_i,
   input  logic [NumInputs-1:0]                last_i,
   output logic                                valid_o,
   input  logic                                ready_i,
   output logic [DataWidth-1:0]                data_o,
   output logic                                last_o,
   output logic [IdxWidth-1:0]                 gnt_idx_o,
   output logic                                locked_o
);

   arb_state_e          state_reg, state_next;
   logic [IdxWidth-1:0] lock_idx_reg, lock_idx_next;
   logic [IdxWidth-1:0] rr_ptr_reg, rr_ptr_next;
   logic [IdxWidth-1:0] pick_idx;
   logic                pick_any;
   logic [IdxWidth-1:0] serve_idx;
   logic                hs;

   function automatic logic [IdxWidth-1:0] wrap_inc(input logic [IdxWidth-1:0] v);
      if (v == IdxWidth'(NumInputs - 1)) begin
         return '0;
      end
      return v + IdxWidth'(1);
   endfunction

   floo_rr_pick #(
      .NumReq   (NumInputs),
      .IdxWidth (IdxWidth)
   ) u_pick (
      .req    (valid_i),
      .rr_ptr (rr_ptr_reg),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // While locked the picker result is ignored, so a stalled or bubbling
   // packet keeps the link even if other inputs are requesting.
   assign serve_idx = (state_reg == ARB_LOCKED) ? lock_idx_reg : pick_idx;
   assign gnt_idx_o = serve_idx;
   assign valid_o   = valid_i[serve_idx];
   assign data_o    = data_i[serve_idx];
   assign last_o    = last_i[serve_idx];
   assign locked_o  = (state_reg == ARB_LOCKED);
   assign hs        = valid_o && ready_i;

   for (genvar gi = 0; gi < NumInputs; gi++) begin : g_ready
      assign ready_o[gi] = ready_i && (serve_idx == IdxWidth'(gi)) &&
                           ((state_reg == ARB_LOCKED) || valid_i[gi]);
   end

   always_comb begin
      state_next    = state_reg;
      lock_idx_next = lock_idx_reg;
      rr_ptr_next   = rr_ptr_reg;
      case (state_reg)
         ARB_IDLE: begin
            if (pick_any) begin
               if (hs && last_o) begin
                  rr_ptr_next = wrap_inc(pick_idx);
               end else begin
                  // Lock even on a stalled first flit so the source cannot switch.
                  state_next    = ARB_LOCKED;
                  lock_idx_next = pick_idx;
               end
            end
         end
         ARB_LOCKED: begin
            if (hs && last_o) begin
               state_next  = ARB_IDLE;
               rr_ptr_next = wrap_inc(lock_idx_reg);
            end
         end
         default: begin
            state_next = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg    <= ARB_IDLE;
         lock_idx_reg <= '0;
         rr_ptr_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         lock_idx_reg <= lock_idx_next;
         rr_ptr_reg   <= rr_ptr_next;
      end
   end

endmodule
